// File: rtl/cache_pkg.sv
// cache_pkg: shared types and defaults for the direct-mapped write-through cache.
//   state_t      : sequencer states
//   MODE_READ/WRITE : request mode encoding
//   DEF_*        : default widths for the controller and storage
package cache_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_INDEX_W = 12;
  localparam int DEF_CNT_W   = 16;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM, RESP} state_t;
endpackage

// File: rtl/cache_array.sv
// cache_array: valid/tag/data storage for 2^INDEX_W direct-mapped lines.
//   clk, rst      : clock, synchronous active-high reset (clears valid only)
//   idx           : line index for both read and write
//   vld/tag/rdata : asynchronous read of the indexed line
//   we/wtag/wdata : synchronous line write, also sets the valid bit
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  output logic               vld,
  output logic [TAG_W-1:0]   tag,
  output logic [DATA_W-1:0]  rdata,
  input  logic               we,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [DATA_W-1:0]  wdata
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] mem  [LINES];

  assign vld   = valid[idx];
  assign tag   = tags[idx];
  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (rst)     valid      <= '0;
    else if (we) valid[idx] <= 1'b1;
  end

  // Tag/data are not cleared; a cleared valid bit hides stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx] <= wtag;
      mem[idx]  <= wdata;
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: single-requester sequencer for a direct-mapped, write-through,
// write-allocate cache in front of a word-addressed RAM.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake; address/data/mode latched on accept
//   resp_valid/out/hit       : one-cycle completion pulse; out/hit hold until next response
//   ram_req/ram_we/ram_addr/ram_wdata/ram_rdata/ram_ack : RAM handshake, held until ack
//   hit_cnt/miss_cnt         : saturating response counters
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  output logic              resp_valid,
  output logic [DATA_W-1:0] out,
  output logic              hit,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              mode_q;
  logic              look_hit;

  logic              a_vld, a_we, lhit;
  logic [TAG_W-1:0]  a_tag;
  logic [DATA_W-1:0] a_data, fill;

  cache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_arr (
    .clk   (clk),
    .rst   (rst),
    .idx   (addr_q[INDEX_W-1:0]),
    .vld   (a_vld),
    .tag   (a_tag),
    .rdata (a_data),
    .we    (a_we),
    .wtag  (addr_q[ADDR_W-1:INDEX_W]),
    .wdata (fill)
  );

  assign lhit      = a_vld && (a_tag == addr_q[ADDR_W-1:INDEX_W]);
  assign fill      = (mode_q == MODE_WRITE) ? data_q : ram_rdata;
  assign ram_addr  = addr_q;
  assign ram_wdata = data_q;

  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    a_we       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = LOOKUP;
      end
      LOOKUP: nxt = (mode_q == MODE_READ && lhit) ? RESP : MEM;
      MEM: begin
        ram_req = 1'b1;
        ram_we  = (mode_q == MODE_WRITE);
        if (ram_ack) begin
          a_we = !rst;   // an aborted fill must not land in the array
          nxt  = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      mode_q   <= MODE_READ;
      look_hit <= 1'b0;
      out      <= '0;
      hit      <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (req_valid) begin
          addr_q <= address;
          data_q <= data;
          mode_q <= mode;
        end
        LOOKUP: begin
          // Kept separately so hit/out only change when a response is formed.
          look_hit <= lhit;
          if (mode_q == MODE_READ && lhit) begin
            out <= a_data;
            hit <= 1'b1;
          end
        end
        MEM: if (ram_ack) begin
          out <= fill;
          hit <= look_hit;
        end
        RESP: begin
          if (hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed + randomized bench against a transaction-level cache
// model. A second instance with 3-bit counters shares all inputs so counter
// saturation is reached within a short run.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, mode = 1'b0, ram_ack = 1'b0;
  logic [31:0] address = '0, data = '0, ram_rdata = '0;
  logic        req_ready, resp_valid, hit, ram_req, ram_we;
  logic [31:0] out, ram_addr, ram_wdata;
  logic [15:0] hit_cnt, miss_cnt;
  logic        s_req_ready, s_resp_valid, s_hit, s_ram_req, s_ram_we;
  logic [31:0] s_out, s_ram_addr, s_ram_wdata;
  logic [2:0]  s_hit_cnt, s_miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .data(data), .mode(mode), .resp_valid(resp_valid),
    .out(out), .hit(hit), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_ctrl #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .address(address), .data(data), .mode(mode), .resp_valid(s_resp_valid),
    .out(s_out), .hit(s_hit), .ram_req(s_ram_req), .ram_we(s_ram_we),
    .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  int errs = 0, nchk = 0;

  // Reference model: one entry per index, plus response counters.
  bit          mv [4096];
  logic [19:0] mt [4096];
  logic [31:0] md [4096];
  int          hc, mc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 4096; i++) mv[i] = 1'b0;
    hc = 0;
    mc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; ram_ack = 1'b0;
    address = '0; data = '0; mode = 1'b0; ram_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clr_model();
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", resp_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_hit", hit, 0);
    chk("rst_ram_req", ram_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
  endtask

  // One full transaction; called at a negedge with the DUT idle. dly is the
  // number of cycles ram_ack is held low after ram_req rises.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic m,
                         input int dly, input logic [31:0] rd);
    int          idx;
    logic        h;
    logic [31:0] eo;
    idx = int'(a[11:0]);
    h   = mv[idx] && (mt[idx] == a[31:12]);
    if (!m && h) eo = md[idx];
    else begin
      eo      = m ? d : rd;
      mv[idx] = 1'b1;
      mt[idx] = a[31:12];
      md[idx] = eo;
    end
    if (h) hc++; else mc++;

    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; address = a; data = d; mode = m; ram_ack = 1'b0;
    @(negedge clk);
    // Junk on the request port must be ignored while busy.
    req_valid = 1'($urandom); address = $urandom; data = $urandom; mode = 1'($urandom);
    chk("lk_ready", req_ready, 0);
    chk("lk_ram_req", ram_req, 0);
    chk("lk_resp", resp_valid, 0);
    @(negedge clk);
    if (m || !h) begin
      chk("mem_req", ram_req, 1);
      chk("mem_we", ram_we, m);
      chk("mem_addr", ram_addr, a);
      chk("mem_wdata", ram_wdata, d);
      chk("mem_resp", resp_valid, 0);
      chk("s_mem_req", s_ram_req, 1);
      chk("s_mem_we", s_ram_we, m);
      chk("s_mem_addr", s_ram_addr, a);
      chk("s_mem_wdata", s_ram_wdata, d);
      for (int i = 0; i < dly; i++) begin
        ram_rdata = $urandom;
        @(negedge clk);
        chk("stall_req", ram_req, 1);
        chk("stall_addr", ram_addr, a);
        chk("stall_wdata", ram_wdata, d);
        chk("stall_we", ram_we, m);
        chk("stall_ready", req_ready, 0);
        chk("stall_resp", resp_valid, 0);
      end
      ram_ack = 1'b1; ram_rdata = rd;
      @(negedge clk);
      ram_ack = 1'b0; ram_rdata = $urandom;
      chk("resp_ram_req", ram_req, 0);
    end else begin
      chk("hit_no_req", ram_req, 0);
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_out", out, eo);
    chk("resp_hit", hit, h);
    chk("s_resp_valid", s_resp_valid, 1);
    chk("s_resp_out", s_out, eo);
    chk("s_resp_hit", s_hit, h);

    // Stray ram_ack while idle must be ignored.
    req_valid = 1'b0; ram_ack = 1'($urandom);
    @(negedge clk);
    ram_ack = 1'b0;
    chk("post_ready", req_ready, 1);
    chk("s_post_ready", s_req_ready, 1);
    chk("post_resp", resp_valid, 0);
    chk("post_ram_req", ram_req, 0);
    chk("hold_out", out, eo);
    chk("hold_hit", hit, h);
    chk("hit_cnt", hit_cnt, 64'(hc));
    chk("miss_cnt", miss_cnt, 64'(mc));
    chk("sat_hit_cnt", s_hit_cnt, 64'(sat7(hc)));
    chk("sat_miss_cnt", s_miss_cnt, 64'(sat7(mc)));
  endtask

  initial begin
    logic [31:0] a;
    do_reset();

    // Cold read miss.
    run_req(32'd0, 32'd0, MODE_READ, 1, 32'd14528);
    chk("t1_out", out, 14528);
    chk("t1_miss_cnt", miss_cnt, 1);

    // Write then read-hit at index 3036.
    run_req(32'd2816867292, 32'd526421, MODE_WRITE, 2, $urandom);
    run_req(32'd2816867292, 32'd0, MODE_READ, 0, $urandom);
    chk("t2_hit", hit, 1);
    chk("t2_out", out, 526421);

    // Two writes to the same line; read returns the latest.
    run_req(32'd1001425, 32'd25369366, MODE_WRITE, 0, $urandom);
    run_req(32'd1001425, 32'd14528, MODE_WRITE, 3, $urandom);
    run_req(32'd1001425, 32'd0, MODE_READ, 0, $urandom);
    chk("t3_out", out, 14528);

    // Conflict on index 0.
    do_reset();
    run_req(32'd0, 32'd0, MODE_READ, 1, 32'd5);
    run_req(32'd4096, 32'd0, MODE_READ, 1, 32'd6);
    run_req(32'd0, 32'd0, MODE_READ, 1, 32'd7);
    chk("conflict_miss", miss_cnt, 3);
    chk("conflict_out", out, 7);

    // Long stalls, and ack in the same cycle ram_req rises.
    run_req(32'd777, 32'd0, MODE_READ, 10, 32'd42);
    run_req(32'd888, 32'd99, MODE_WRITE, 10, $urandom);
    run_req(32'd555, 32'd0, MODE_READ, 0, 32'd9);

    // Reset in the middle of MEM aborts the access and invalidates the cache.
    a = 32'h0001_2345;
    run_req(a, 32'd11, MODE_WRITE, 1, $urandom);
    req_valid = 1'b1; address = a; data = 32'd22; mode = MODE_WRITE;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_req", ram_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ram_req", ram_req, 0);
    chk("abort_resp", resp_valid, 0);
    chk("abort_hit_cnt", hit_cnt, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    clr_model();
    @(negedge clk);
    chk("abort_no_resp", resp_valid, 0);
    run_req(a, 32'd0, MODE_READ, 2, 32'd77);
    chk("abort_then_miss", hit, 0);
    chk("abort_then_out", out, 77);

    // Random traffic over a small address pool so hits and conflicts occur.
    for (int n = 0; n < 300; n++) begin
      a = {20'($urandom_range(0, 2)), 12'($urandom_range(0, 7))};
      if ($urandom_range(0, 9) == 0) a = $urandom;
      run_req(a, $urandom, 1'($urandom), int'($urandom_range(0, 4)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Request sequencer for the direct-mapped, write-through cache in front of the word-addressed RAM. Accepts one read or write at a time from a single requester, performs the tag lookup, drives the multi-cycle RAM handshake on misses and on every write, updates the line, and returns a one-cycle response. It sits between the core-side address/data/mode interface and the RAM port, and it owns the tag/valid/data storage.

## Interface
- ADDR_W, 32, address width (word address)
- DATA_W, 32, data width
- INDEX_W, 12, index bits; 2^INDEX_W lines (4096), index = address % 4096
- CNT_W, 16, width of the hit/miss counters

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- address  in  ADDR_W  request word address
- data  in  DATA_W  write data (ignored on read)
- mode  in  1  1 = write, 0 = read
- resp_valid  out  1  one-cycle pulse: request complete
- out  out  DATA_W  read data, or the written data on a write
- hit  out  1  qualified by resp_valid: request hit in cache
- ram_req  out  1  RAM access request, held until ram_ack
- ram_we  out  1  1 = RAM write
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM access complete, one-cycle pulse
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

## Operation
- Field split: index = address[INDEX_W-1:0]; tag = address[ADDR_W-1:INDEX_W]. Hit = line valid and stored tag equals request tag.
- States: IDLE, LOOKUP, MEM, RESP.
- IDLE: req_ready = 1. On req_valid, latch address, data and mode; go to LOOKUP. No other state accepts.
- LOOKUP: compare tags. Read hit: load out from the line, set hit = 1, go to RESP. Read miss or any write: go to MEM.
- MEM: ram_req = 1, ram_we = mode, ram_addr = latched address, ram_wdata = latched data, all stable until ram_ack. On ram_ack, write the line (valid = 1, tag, and data = ram_rdata on a read or latched data on a write). Set out to the same value, set hit to the LOOKUP result, and go to RESP.
- Writes are write-through and write-allocate: every write goes to RAM, and a write miss replaces the line.
- RESP: resp_valid = 1 for this one cycle; go to IDLE.
- Counters: at RESP, hit_cnt increments on a hit, otherwise miss_cnt increments. Each saturates at all-ones.
- ram_ack outside MEM is ignored.

## Timing
- Values after a reset edge: state IDLE, req_ready 1, resp_valid 0, out 0, hit 0, ram_req 0, ram_we 0, ram_addr 0, ram_wdata 0, hit_cnt 0, miss_cnt 0, all valid bits 0. Tag and data arrays are not cleared.
- Read hit: accepted at edge N; resp_valid high in cycle N+2; req_ready high again in N+3.
- Miss or write: ram_req rises in cycle N+2. If ram_ack arrives in cycle M (M ≥ N+2, including the same cycle ram_req rises), resp_valid is high in M+1 and ram_req is low from M+1.
- out and hit hold their value after RESP until the next response.
- rst asserted in any state aborts the operation: no resp_valid, ram_req low on the next cycle, line not written, counters cleared.
- A request targeting the same index as the line just written sees the updated line.

## Structure
- Shared package cache_pkg holds:
  - the state enum;
  - MODE_READ / MODE_WRITE constants;
  - default ADDR_W, DATA_W and INDEX_W.
- Sub-module cache_array holds the storage:
  - valid vector, tag RAM and data RAM;
  - asynchronous read by index, synchronous write;
  - synchronous valid clear on rst.
- cache_ctrl holds the FSM, request latches, RAM port registers and counters.

## Test plan
- Reset, then read address 0 → miss: ram_req with ram_we = 0, RAM returns 14528, resp_valid with out = 14528 and hit = 0; miss_cnt = 1.
- Write 526421 to 2816867292 (index 3036), then read the same address → write goes to RAM with ram_wdata = 526421; the read hits with no ram_req, out = 526421 and hit = 1, resp_valid two cycles after acceptance.
- Write 25369366, then 14528, to 1001425 (index 2001), then read it → both writes reach RAM; the read hits with out = 14528.
- Conflict: read 0, then read 4096 (same index 0, tag 1), then read 0 → three misses, each followed by a fill; miss_cnt = 3.
- RAM stall: hold ram_ack low for 10 cycles → ram_req, ram_addr and ram_wdata stay stable, and req_valid is ignored (req_ready = 0) throughout. Separately, ram_ack in the same cycle ram_req rises → resp_valid in the following cycle.
- rst asserted mid-MEM → ram_req drops the next cycle, no resp_valid, and a subsequent read of that address misses. Separately, force hit_cnt to 0xFFFF → one more hit leaves it at 0xFFFF.
